// File: rtl/hana_i2c_writer_pkg.sv
// Shared constants, FSM state type and pad-drive decode for the HANA I2C register writer.
package hana_pkg;

  localparam logic [6:0]  HANA_I2C_ADDR = 7'h70;
  localparam int unsigned HANA_CLK_DIV  = 30;
  localparam logic [2:0]  LAST_BYTE     = 3'd5;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} i2c_state_e;

  function automatic logic [47:0] build_frame(logic [6:0] dev, logic [7:0] rega, logic [31:0] d);
    return {dev, 1'b0, rega, d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Returns {scl_oe, sda_oe} for a given phase; 1 pulls the line low.
  function automatic logic [1:0] pad_drive(i2c_state_e st, logic [1:0] qtr, logic msb);
    logic scl_low;
    scl_low = (qtr == 2'd0) || (qtr == 2'd3);
    case (st)
      START:   return {qtr == 2'd3, qtr != 2'd0};
      BIT:     return {scl_low, ~msb};
      ACK:     return {scl_low, 1'b0};
      STOP:    return {qtr == 2'd0, ~qtr[1]};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hana_i2c_writer_if.sv
// Request/status handshake plus open-drain pad controls of the HANA I2C writer.
interface hana_i2c_writer_if;
  logic        start;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        nack;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_in;

  modport master (output start, dev_addr, reg_addr, wr_data, sda_in,
                  input  busy, done, nack, scl_oe, sda_oe);
  modport slave  (input  start, dev_addr, reg_addr, wr_data, sda_in,
                  output busy, done, nack, scl_oe, sda_oe);
endinterface

// File: rtl/hana_i2c_writer_tick.sv
// Quarter-bit strobe generator: one-cycle pulse every CLK_DIV system clocks.
module hana_i2c_tick #(
  parameter int unsigned CLK_DIV = 30
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic strobe_o
);

  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q + 1'b1;
    if (restart_i || (tick_q == LAST)) tick_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= '0;
    else         tick_q <= tick_d;
  end

  assign strobe_o = (tick_q == LAST);

endmodule

// File: rtl/hana_i2c_writer.sv
// HANA register write over I2C: START, addr+W, reg index, 4 data bytes LSB-byte first, STOP.
module hana_i2c_writer
  import hana_pkg::*;
#(
  parameter int unsigned CLK_DIV = HANA_CLK_DIV
) (
  input  logic               clk_48m,
  input  logic               rst_n,
  hana_i2c_writer_if.slave   bus
);

  i2c_state_e  state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [47:0] frame_q, frame_d;
  logic        ack_hi_q, ack_hi_d;
  logic        nack_q, nack_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [1:0]  sync_q;
  logic        strobe;
  logic        accept;

  hana_i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i     (clk_48m),
    .rst_ni    (rst_n),
    .restart_i (accept),
    .strobe_o  (strobe)
  );

  always_comb begin
    state_d  = state_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    frame_d  = frame_q;
    ack_hi_d = ack_hi_q;
    nack_d   = nack_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_d  = START;
          qtr_d    = '0;
          bit_d    = '0;
          byte_d   = '0;
          frame_d  = build_frame(bus.dev_addr, bus.reg_addr, bus.wr_data);
          ack_hi_d = 1'b0;
          nack_d   = 1'b0;
        end
      end
      START: begin
        if (strobe) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) state_d = BIT;
        end
      end
      BIT: begin
        if (strobe) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            frame_d = {frame_q[46:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (strobe) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) ack_hi_d = sync_q[1];
          // The slot always runs its full four quarters so SCL is low before STOP/next byte.
          if (qtr_q == 2'd3) begin
            if (ack_hi_q || (byte_q == LAST_BYTE)) begin
              state_d = STOP;
            end else begin
              byte_d  = byte_q + 3'd1;
              state_d = BIT;
            end
          end
        end
      end
      STOP: begin
        if (strobe) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = DONE;
            nack_d  = ack_hi_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pads are registered from next-state values: glitch-free, no added latency.
    {scl_d, sda_d} = pad_drive(state_d, qtr_d, frame_d[47]);
  end

  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      qtr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      frame_q  <= '0;
      ack_hi_q <= 1'b0;
      nack_q   <= 1'b0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
      sync_q   <= 2'b11;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      ack_hi_q <= ack_hi_d;
      nack_q   <= nack_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      sync_q   <= {sync_q[0], bus.sda_in};
    end
  end

  assign bus.busy   = state_q inside {START, BIT, ACK, STOP};
  assign bus.done   = (state_q == DONE);
  assign bus.nack   = nack_q;
  assign bus.scl_oe = scl_q;
  assign bus.sda_oe = sda_q;

endmodule
